// File: rtl/wb_commit_regs_pkg.sv
// Shared widths, storage types and helpers for the write-back commit slice.
package wb_commit_regs_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t NOP_REG_ADDR = '0;
  localparam reg_t  ZERO_WORD    = '0;

  function automatic logic gpr_commit(logic wreg, addr_t wd);
    return wreg && (wd != NOP_REG_ADDR);
  endfunction

endpackage

// File: rtl/wb_commit_regs_if.sv
// Write-back stage to commit-stage bundle.
interface wb_commit_regs_if;
  import wb_commit_regs_pkg::*;

  addr_t wb_wd;
  logic  wb_wreg;
  reg_t  wb_wdata;
  reg_t  wb_hi;
  reg_t  wb_lo;
  logic  wb_whilo;
  logic  wb_LLbit_we;
  logic  wb_LLbit_value;
  logic  flush;

  modport master (
    output wb_wd, wb_wreg, wb_wdata,
    output wb_hi, wb_lo, wb_whilo,
    output wb_LLbit_we, wb_LLbit_value,
    output flush
  );

  modport slave (
    input wb_wd, wb_wreg, wb_wdata,
    input wb_hi, wb_lo, wb_whilo,
    input wb_LLbit_we, wb_LLbit_value,
    input flush
  );

endinterface

// File: rtl/wb_commit_regs_gpr_array.sv
// 32-entry GPR file, r0 hardwired, one write port and two
// write-first bypassed read ports.
module gpr_array
  import wb_commit_regs_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  addr_t waddr,
  input  reg_t  wdata,
  input  logic  re1,
  input  addr_t raddr1,
  output reg_t  rdata1,
  input  logic  re2,
  input  addr_t raddr2,
  output reg_t  rdata2
);

  reg_t regs [REG_NUM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (gpr_commit(we, waddr)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZERO_WORD;
    if (reset && re1 && raddr1 != NOP_REG_ADDR) begin
      if (we && waddr == raddr1) rdata1 = wdata;
      else                       rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZERO_WORD;
    if (reset && re2 && raddr2 != NOP_REG_ADDR) begin
      if (we && waddr == raddr2) rdata2 = wdata;
      else                       rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_commit_regs.sv
// Commits write-back results to GPR, HI/LO and LLbit state,
// with bypassed reads and a committed-write counter.
module wb_commit_regs
  import wb_commit_regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  wb_commit_regs_if.slave    wb,
  input  logic               re1,
  input  addr_t              raddr1,
  output reg_t               rdata1,
  input  logic               re2,
  input  addr_t              raddr2,
  output reg_t               rdata2,
  output reg_t               hi_o,
  output reg_t               lo_o,
  output logic               LLbit_o,
  output logic [CNT_W-1:0]   wb_cnt_o
);

  reg_t             hi_q;
  reg_t             lo_q;
  logic             ll_q;
  logic [CNT_W-1:0] cnt_q;

  gpr_array u_gpr (
    .clk    (clk),
    .reset  (reset),
    .we     (wb.wb_wreg),
    .waddr  (wb.wb_wd),
    .wdata  (wb.wb_wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= ZERO_WORD;
      lo_q  <= ZERO_WORD;
      ll_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (wb.wb_whilo) begin
        hi_q <= wb.wb_hi;
        lo_q <= wb.wb_lo;
      end
      // flush wins over a concurrent LL/SC update
      if (wb.flush)            ll_q <= 1'b0;
      else if (wb.wb_LLbit_we) ll_q <= wb.wb_LLbit_value;
      if (gpr_commit(wb.wb_wreg, wb.wb_wd)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hi_o    = ZERO_WORD;
    lo_o    = ZERO_WORD;
    LLbit_o = 1'b0;
    if (reset) begin
      hi_o = wb.wb_whilo ? wb.wb_hi : hi_q;
      lo_o = wb.wb_whilo ? wb.wb_lo : lo_q;
      if (!wb.flush) begin
        LLbit_o = wb.wb_LLbit_we ? wb.wb_LLbit_value : ll_q;
      end
    end
  end

  assign wb_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_commit_regs.sv
// Self-checking bench: directed vector table, hand-written reset and
// counter-wrap sequences, then randomized traffic against a model.
module tb_wb_commit_regs;

  logic        clk;
  logic        reset;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, cnt;
  logic        ll_o;
  logic [31:0] s_rd1, s_rd2, s_hi, s_lo;
  logic        s_ll;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  wb_commit_regs_if wb_if ();

  wb_commit_regs dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb_if.slave),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .LLbit_o  (ll_o),
    .wb_cnt_o (cnt)
  );

  // narrow counter copy so the wrap boundary is reachable quickly
  wb_commit_regs #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb_if.slave),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (s_rd1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (s_rd2),
    .hi_o     (s_hi),
    .lo_o     (s_lo),
    .LLbit_o  (s_ll),
    .wb_cnt_o (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference architectural state
  logic [31:0] mregs [32];
  logic [31:0] mhi, mlo;
  logic        mll;
  int unsigned mcnt;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic        llwe, llval, flush;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e_rd1, e_rd2, e_hi, e_lo;
    logic        e_ll;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    int wreg, int wd, logic [31:0] wdata,
    int whilo, logic [31:0] hi, logic [31:0] lo,
    int llwe, int llval, int flush,
    int r1e, int ra1, int r2e, int ra2,
    logic [31:0] e1, logic [31:0] e2,
    logic [31:0] eh, logic [31:0] el,
    int ell, logic [31:0] ec);
    vec_t v;
    v.wreg  = 1'(wreg);
    v.wd    = 5'(wd);
    v.wdata = wdata;
    v.whilo = 1'(whilo);
    v.hi    = hi;
    v.lo    = lo;
    v.llwe  = 1'(llwe);
    v.llval = 1'(llval);
    v.flush = 1'(flush);
    v.re1   = 1'(r1e);
    v.ra1   = 5'(ra1);
    v.re2   = 1'(r2e);
    v.ra2   = 5'(ra2);
    v.e_rd1 = e1;
    v.e_rd2 = e2;
    v.e_hi  = eh;
    v.e_lo  = el;
    v.e_ll  = 1'(ell);
    v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_if.wb_wreg        = 1'b0;
    wb_if.wb_wd          = '0;
    wb_if.wb_wdata       = '0;
    wb_if.wb_whilo       = 1'b0;
    wb_if.wb_hi          = '0;
    wb_if.wb_lo          = '0;
    wb_if.wb_LLbit_we    = 1'b0;
    wb_if.wb_LLbit_value = 1'b0;
    wb_if.flush          = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mhi  = '0;
    mlo  = '0;
    mll  = 1'b0;
    mcnt = 0;
  endtask

  // one rising edge; the model absorbs the inputs that edge commits
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      if (wb_if.wb_wreg && wb_if.wb_wd != 0) begin
        mregs[wb_if.wb_wd] = wb_if.wb_wdata;
        mcnt = mcnt + 1;
      end
      if (wb_if.wb_whilo) begin
        mhi = wb_if.wb_hi;
        mlo = wb_if.wb_lo;
      end
      if (wb_if.flush)            mll = 1'b0;
      else if (wb_if.wb_LLbit_we) mll = wb_if.wb_LLbit_value;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(logic re, logic [4:0] a);
    if (!reset || !re || a == 0)              return '0;
    if (wb_if.wb_wreg && wb_if.wb_wd == a)    return wb_if.wb_wdata;
    return mregs[a];
  endfunction

  task automatic check_model(string tag);
    logic [31:0] eh, el;
    logic        ell;
    logic [31:0] ec4;
    eh  = !reset ? '0 : (wb_if.wb_whilo ? wb_if.wb_hi : mhi);
    el  = !reset ? '0 : (wb_if.wb_whilo ? wb_if.wb_lo : mlo);
    ell = !reset ? 1'b0 : (wb_if.flush ? 1'b0 :
          (wb_if.wb_LLbit_we ? wb_if.wb_LLbit_value : mll));
    ec4 = mcnt % 16;
    chk({tag, ".rd1"},  rdata1, exp_rd(re1, raddr1));
    chk({tag, ".rd2"},  rdata2, exp_rd(re2, raddr2));
    chk({tag, ".hi"},   hi_o, eh);
    chk({tag, ".lo"},   lo_o, el);
    chk({tag, ".ll"},   {31'b0, ll_o}, {31'b0, ell});
    chk({tag, ".cnt"},  cnt, mcnt);
    chk({tag, ".cnt4"}, {28'b0, s_cnt}, ec4);
  endtask

  initial begin
    idle();
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
    model_clear();
    reset = 1'b0;
    #12;
    chk("rst.cnt", cnt, 32'h0);
    chk("rst.hi",  hi_o, 32'h0);
    reset = 1'b1;
    tick();

    tbl[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7,
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7,
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7,
                 0, 32'hDEADBEEF, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7,
                 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 9, 32'h99, 1, 32'hA, 32'hB, 0, 0, 0, 0, 7, 1, 9,
                 0, 32'h99, 32'hA, 32'hB, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 7,
                 32'h99, 32'hDEADBEEF, 32'hA, 32'hB, 0, 2);
    tbl[6]  = mk(0, 0, 0, 1, 32'hC, 32'hD, 0, 0, 0, 1, 9, 1, 3,
                 32'h99, 0, 32'hC, 32'hD, 0, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 7, 1, 9,
                 32'hDEADBEEF, 32'h99, 32'hC, 32'hD, 1, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7, 1, 9,
                 32'hDEADBEEF, 32'h99, 32'hC, 32'hD, 0, 2);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 9,
                 32'hDEADBEEF, 32'h99, 32'hC, 32'hD, 0, 2);
    tbl[10] = mk(1, 7, 32'h7777, 0, 0, 0, 1, 1, 0, 1, 7, 1, 7,
                 32'h7777, 32'h7777, 32'hC, 32'hD, 1, 2);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 9,
                 32'h7777, 32'h99, 32'hC, 32'hD, 0, 3);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 9,
                 32'h7777, 32'h99, 32'hC, 32'hD, 0, 3);

    for (int i = 0; i < 13; i++) begin
      wb_if.wb_wreg        = tbl[i].wreg;
      wb_if.wb_wd          = tbl[i].wd;
      wb_if.wb_wdata       = tbl[i].wdata;
      wb_if.wb_whilo       = tbl[i].whilo;
      wb_if.wb_hi          = tbl[i].hi;
      wb_if.wb_lo          = tbl[i].lo;
      wb_if.wb_LLbit_we    = tbl[i].llwe;
      wb_if.wb_LLbit_value = tbl[i].llval;
      wb_if.flush          = tbl[i].flush;
      re1 = tbl[i].re1; raddr1 = tbl[i].ra1;
      re2 = tbl[i].re2; raddr2 = tbl[i].ra2;
      #1;
      chk($sformatf("v%0d.rd1", i), rdata1, tbl[i].e_rd1);
      chk($sformatf("v%0d.rd2", i), rdata2, tbl[i].e_rd2);
      chk($sformatf("v%0d.hi", i),  hi_o, tbl[i].e_hi);
      chk($sformatf("v%0d.lo", i),  lo_o, tbl[i].e_lo);
      chk($sformatf("v%0d.ll", i),  {31'b0, ll_o}, {31'b0, tbl[i].e_ll});
      chk($sformatf("v%0d.cnt", i), cnt, tbl[i].e_cnt);
      tick();
    end

    // asynchronous reset mid-cycle with bypass traffic present
    idle();
    wb_if.wb_wreg = 1'b1; wb_if.wb_wd = 5'd5; wb_if.wb_wdata = 32'h1234;
    wb_if.wb_whilo = 1'b1; wb_if.wb_hi = 32'h55;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    chk("pre.rd1", rdata1, 32'h1234);
    chk("pre.hi",  hi_o, 32'h55);
    wb_if.wb_wreg = 1'b1; wb_if.wb_wd = 5'd5; wb_if.wb_wdata = 32'hABCD;
    wb_if.wb_whilo = 1'b1; wb_if.wb_hi = 32'h66;
    wb_if.wb_LLbit_we = 1'b1; wb_if.wb_LLbit_value = 1'b1;
    reset = 1'b0;
    #1;
    chk("ar.rd1", rdata1, 32'h0);
    chk("ar.rd2", rdata2, 32'h0);
    chk("ar.hi",  hi_o, 32'h0);
    chk("ar.ll",  {31'b0, ll_o}, 32'h0);
    chk("ar.cnt", cnt, 32'h0);
    model_clear();
    #1;
    idle();
    reset = 1'b1;
    tick();
    chk("rel.rd1", rdata1, 32'h0);
    chk("rel.hi",  hi_o, 32'h0);
    chk("rel.cnt", cnt, 32'h0);

    // drive the narrow counter to its top value, then wrap on an r3 commit
    for (int i = 0; i < 15; i++) begin
      wb_if.wb_wreg  = 1'b1;
      wb_if.wb_wd    = 5'($urandom_range(1, 31));
      wb_if.wb_wdata = $urandom;
      tick();
    end
    idle();
    #1;
    chk("wrap.pre4", {28'b0, s_cnt}, 32'hF);
    chk("wrap.pre",  cnt, 32'd15);
    wb_if.wb_wreg = 1'b1; wb_if.wb_wd = 5'd3; wb_if.wb_wdata = 32'h3333_0003;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    chk("wrap.cnt4", {28'b0, s_cnt}, 32'h0);
    chk("wrap.cnt",  cnt, 32'd16);
    chk("wrap.r3",   rdata1, 32'h3333_0003);

    for (int n = 0; n < 400; n++) begin
      wb_if.wb_wreg        = 1'($urandom_range(0, 1));
      wb_if.wb_wd          = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) wb_if.wb_wd = 5'($urandom);
      wb_if.wb_wdata       = $urandom;
      wb_if.wb_whilo       = 1'($urandom_range(0, 1));
      wb_if.wb_hi          = $urandom;
      wb_if.wb_lo          = $urandom;
      wb_if.wb_LLbit_we    = 1'($urandom_range(0, 1));
      wb_if.wb_LLbit_value = 1'($urandom_range(0, 1));
      wb_if.flush          = ($urandom_range(0, 7) == 0);
      re1    = ($urandom_range(0, 7) != 0);
      re2    = ($urandom_range(0, 7) != 0);
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 7));
      #1;
      check_model($sformatf("r%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_regs.md
Name: wb_commit_regs

Overview:
- Write-back consumer at the end of the pipeline. It takes the write-back stage outputs (GPR write, HI/LO write, LLbit write) and commits them to architectural state.
- Holds the 32x32 GPR file, the HI/LO pair and the LLbit.
- Provides combinational read ports with same-cycle write-first bypass to the decode stage and to the mem-stage LL/SC logic.
- Also keeps a free-running count of committed GPR writes for debug and performance visibility.

Parameters:
- DATA_W, 32, width of GPR, HI, LO and write data.
- ADDR_W, 5, GPR address width.
- REG_NUM, 32, number of GPRs (2**ADDR_W).
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- wb_wd  in  ADDR_W  GPR destination from write-back stage.
- wb_wreg  in  1  GPR write enable.
- wb_wdata  in  DATA_W  GPR write data.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- wb_whilo  in  1  HI/LO write enable.
- wb_LLbit_we  in  1  LLbit write enable.
- wb_LLbit_value  in  1  LLbit write value.
- flush  in  1  exception/eret flush; clears LLbit.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data.
- hi_o  out  DATA_W  HI value, bypassed.
- lo_o  out  DATA_W  LO value, bypassed.
- LLbit_o  out  1  LLbit value, bypassed.
- wb_cnt_o  out  CNT_W  committed GPR write count.

Behaviour:
- Reset (reset=0, asynchronous):
  - All GPRs, HI, LO, LLbit and the counter clear to 0 immediately, without waiting for a clock edge.
  - While reset=0, rdata1, rdata2, hi_o, lo_o and LLbit_o are forced to 0; bypass is ignored.
  - Deassertion takes effect at the next rising edge.
- GPR write: at posedge, if wb_wreg=1 and wb_wd!=0, regs[wb_wd] <= wb_wdata. Writes to r0 are discarded, so r0 always reads 0.
- GPR read (combinational, per port, priority order):
  - re=0 -> 0.
  - raddr=0 -> 0.
  - wb_wreg=1 and wb_wd==raddr -> wb_wdata (write-first bypass, zero added latency).
  - Otherwise regs[raddr].
  - Both ports may read the same address, and may hit the bypass, in the same cycle.
- HI/LO:
  - At posedge, if wb_whilo=1, HI <= wb_hi and LO <= wb_lo (both always written together).
  - hi_o/lo_o = wb_whilo ? wb_hi/wb_lo : stored HI/LO.
- LLbit:
  - At posedge, flush=1 -> LLbit <= 0, overriding any simultaneous wb_LLbit_we.
  - Otherwise, if wb_LLbit_we=1, LLbit <= wb_LLbit_value.
  - LLbit_o follows the same priority combinationally: flush ? 0 : (wb_LLbit_we ? wb_LLbit_value : LLbit).
- flush does not block GPR or HI/LO commits. The write-back stage already presents bubbles (wb_wreg=0, wb_whilo=0) when squashed.
- Counter:
  - At posedge, increments by 1 when wb_wreg=1 and wb_wd!=0.
  - Wraps from 2**CNT_W-1 to 0 with no saturation or flag.
  - wb_cnt_o is the registered value (one-cycle latency after the commit edge).
- Latency: a write is architecturally visible in storage one edge after it is presented, and visible via bypass in the same cycle.

Decomposition:
- Shared constants go in defines.v: RegBus, RegAddrBus, RegNum, Zero32h, NOPRegAddr, ReadEnable/ReadDisable, WriteEnable/WriteDisable.
- One sub-module: gpr_array. It holds the REG_NUM x DATA_W storage, the r0 hardwire, the write port, and two bypassed read ports.
- wb_commit_regs instantiates gpr_array and adds the HI/LO, LLbit and counter logic.

Test Plan:
1. Assert reset=0 mid-run after writing r5=0x1234 and HI=0x55 -> rdata1 (raddr1=5, re1=1)=0, hi_o=0, LLbit_o=0 immediately. After release, raddr1=5 still reads 0 and wb_cnt_o=0.
2. Same cycle: wb_wreg=1, wb_wd=7, wb_wdata=0xDEADBEEF; raddr1=raddr2=7, re1=re2=1 -> both rdata=0xDEADBEEF that cycle. Next cycle, with wb_wreg=0, both still read 0xDEADBEEF and wb_cnt_o has incremented by 1.
3. Write wb_wd=0, wb_wdata=0xFFFFFFFF, wb_wreg=1; read raddr1=0 -> rdata1=0 in both cycles, and wb_cnt_o is unchanged. Separately, re1=0 with raddr1=7 -> rdata1=0.
4. wb_whilo=1, wb_hi=0xA, wb_lo=0xB -> hi_o=0xA and lo_o=0xB the same cycle; they hold after wb_whilo drops. Then wb_whilo=1 with 0xC/0xD -> hi_o=0xC and lo_o=0xD immediately.
5. wb_LLbit_we=1, wb_LLbit_value=1 -> LLbit_o=1. Next, flush=1 together with wb_LLbit_we=1, value=1 -> LLbit_o=0 that cycle and LLbit stays 0 after the edge.
6. Preload the counter to 0xFFFFFFFF via 2**32-1 commits (or force it in the bench), then one commit to r3 -> wb_cnt_o=0 and r3 is written correctly.
